// File: rtl/mure_pkg.sv
// Shared types for the trace-encoder ingress: instruction types, FIFO entry
// layouts, the reader FSM states and the joined record presented to the encoder.
package mure_pkg;

  localparam int ITYPE_LEN = 3;
  localparam int INST_LEN  = 32;
  localparam int XLEN      = 32;
  localparam int CAUSE_LEN = 5;
  localparam int PRIV_LEN  = 2;

  typedef enum logic [ITYPE_LEN-1:0] {
    ITYPE_STD  = 3'd0,
    ITYPE_EXC  = 3'd1,
    ITYPE_INT  = 3'd2,
    ITYPE_ERET = 3'd3,
    ITYPE_NTB  = 3'd4,
    ITYPE_TB   = 3'd5,
    ITYPE_UIJ  = 3'd6,
    ITYPE_RSVD = 3'd7
  } itype_e;

  typedef struct packed {
    itype_e              itype;
    logic [INST_LEN-1:0] iaddr;
    logic                iretire;
    logic                ilastsize;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } common_entry_s;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    WAIT_C = 2'd2
  } rd_state_e;

  typedef struct packed {
    itype_e               itype;
    logic [INST_LEN-1:0]  iaddr;
    logic                 iretire;
    logic                 ilastsize;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } te_record_s;

  // Trap-related uops are the only ones with a companion common-FIFO entry.
  function automatic logic needs_common(itype_e t);
    return (t == ITYPE_EXC) || (t == ITYPE_INT) || (t == ITYPE_ERET);
  endfunction

endpackage

// File: rtl/mure_desync_monitor.sv
// Flags a uop/common FIFO desynchronisation: common data waiting with no uop
// to pair it with for DESYNC_TIMEOUT consecutive cycles. The flag is sticky.
module mure_desync_monitor #(
  parameter int DESYNC_TIMEOUT = 16,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic qualify,
  output logic desync
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DESYNC_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             desync_q;

  always_comb begin
    // NOTE: default every comb output first so no path can infer a latch.
    cnt_d = '0;
    if (!flush && qualify) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      desync_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        desync_q <= 1'b0;
      end else if ((DESYNC_TIMEOUT != 0) && (cnt_d == LIMIT)) begin
        desync_q <= 1'b1;
      end
    end
  end

  assign desync = desync_q;

endmodule

// File: rtl/mure_te_ingress_reader.sv
// Pops the uop FIFO and the sparse common FIFO, re-joins them and offers one
// complete instruction-block record per valid/ready handshake to the encoder.
module mure_te_ingress_reader
  import mure_pkg::*;
#(
  parameter logic [PRIV_LEN-1:0] PRIV_RESET     = 2'b11,
  parameter int                  DESYNC_TIMEOUT = 16,
  parameter int                  CNT_W          = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 uop_empty_i,
  input  uop_entry_s           uop_entry_i,
  output logic                 uop_pop_o,
  input  logic                 common_empty_i,
  input  common_entry_s        common_entry_i,
  output logic                 common_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ITYPE_LEN-1:0] itype_o,
  output logic [INST_LEN-1:0]  iaddr_o,
  output logic                 iretire_o,
  output logic                 ilastsize_o,
  output logic [CAUSE_LEN-1:0] cause_o,
  output logic [XLEN-1:0]      tval_o,
  output logic [PRIV_LEN-1:0]  priv_o,
  output logic                 desync_o
);

  rd_state_e     state_q, state_d;
  te_record_s    rec_q;
  common_entry_s held_q;
  logic          adv, head_nc, load, load_c;

  assign adv     = (state_q != FULL) || ready_i;
  assign head_nc = needs_common(uop_entry_i.itype);
  assign load    = adv && !flush_i && !uop_empty_i && (!head_nc || !common_empty_i);
  assign load_c  = load && head_nc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (adv) begin
      if (uop_empty_i)                    state_d = EMPTY;
      else if (head_nc && common_empty_i) state_d = WAIT_C;
      else                                state_d = FULL;
    end
  end

  // Pops are combinational so a waiting uop leaves the FIFO in the load cycle.
  always_comb begin
    uop_pop_o    = rst_ni && load;
    common_pop_o = rst_ni && load_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_q  <= '{itype: ITYPE_STD, iaddr: '0, iretire: 1'b0, ilastsize: 1'b0,
                  cause: '0, tval: '0, priv: PRIV_RESET};
      held_q <= '{cause: '0, tval: '0, priv: PRIV_RESET};
    end else if (flush_i) begin
      held_q.cause <= '0;
      held_q.tval  <= '0;
    end else if (load) begin
      rec_q.itype     <= uop_entry_i.itype;
      rec_q.iaddr     <= uop_entry_i.iaddr;
      rec_q.iretire   <= uop_entry_i.iretire;
      rec_q.ilastsize <= uop_entry_i.ilastsize;
      if (load_c) begin
        rec_q.cause <= common_entry_i.cause;
        rec_q.tval  <= common_entry_i.tval;
        rec_q.priv  <= common_entry_i.priv;
        held_q      <= common_entry_i;
      end else begin
        rec_q.cause <= held_q.cause;
        rec_q.tval  <= held_q.tval;
        rec_q.priv  <= held_q.priv;
      end
    end
  end

  assign valid_o     = (state_q == FULL);
  assign itype_o     = rec_q.itype;
  assign iaddr_o     = rec_q.iaddr;
  assign iretire_o   = rec_q.iretire;
  assign ilastsize_o = rec_q.ilastsize;
  assign cause_o     = rec_q.cause;
  assign tval_o      = rec_q.tval;
  assign priv_o      = rec_q.priv;

  // Waiting in WAIT_C with common empty is legitimate; only an orphaned common counts.
  mure_desync_monitor #(
    .DESYNC_TIMEOUT(DESYNC_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_desync (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .flush  (flush_i),
    .qualify(!common_empty_i && uop_empty_i && (state_q != WAIT_C)),
    .desync (desync_o)
  );

endmodule

// File: tb/tb_mure_te_ingress_reader.sv
// Directed bench for mure_te_ingress_reader: queue-backed FIFO models feed the
// reader, and each scenario task compares outputs against hand-computed values.
module tb_mure_te_ingress_reader;
  import mure_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 flush_i;
  logic                 uop_empty_i;
  uop_entry_s           uop_entry_i;
  logic                 uop_pop_o;
  logic                 common_empty_i;
  common_entry_s        common_entry_i;
  logic                 common_pop_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [ITYPE_LEN-1:0] itype_o;
  logic [INST_LEN-1:0]  iaddr_o;
  logic                 iretire_o;
  logic                 ilastsize_o;
  logic [CAUSE_LEN-1:0] cause_o;
  logic [XLEN-1:0]      tval_o;
  logic [PRIV_LEN-1:0]  priv_o;
  logic                 desync_o;

  int passed = 0;
  int total  = 0;

  uop_entry_s    uq[$];
  common_entry_s cq[$];
  logic          up, cp;

  mure_te_ingress_reader #(
    .PRIV_RESET    (2'b11),
    .DESYNC_TIMEOUT(8),
    .CNT_W         (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .uop_empty_i   (uop_empty_i),
    .uop_entry_i   (uop_entry_i),
    .uop_pop_o     (uop_pop_o),
    .common_empty_i(common_empty_i),
    .common_entry_i(common_entry_i),
    .common_pop_o  (common_pop_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .itype_o       (itype_o),
    .iaddr_o       (iaddr_o),
    .iretire_o     (iretire_o),
    .ilastsize_o   (ilastsize_o),
    .cause_o       (cause_o),
    .tval_o        (tval_o),
    .priv_o        (priv_o),
    .desync_o      (desync_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic refresh();
    uop_empty_i    = (uq.size() == 0);
    uop_entry_i    = (uq.size() != 0) ? uq[0] : '0;
    common_empty_i = (cq.size() == 0);
    common_entry_i = (cq.size() != 0) ? cq[0] : '0;
  endtask

  task automatic push_uop(input itype_e t, input logic [INST_LEN-1:0] a);
    uq.push_back('{itype: t, iaddr: a, iretire: 1'b1, ilastsize: 1'b0});
    refresh();
  endtask

  task automatic push_com(input logic [CAUSE_LEN-1:0] c, input logic [XLEN-1:0] v,
                          input logic [PRIV_LEN-1:0] p);
    cq.push_back('{cause: c, tval: v, priv: p});
    refresh();
  endtask

  // Capture pops mid-cycle, let the edge pass, then retire popped FIFO heads.
  task automatic cycle();
    @(negedge clk_i);
    up = uop_pop_o;
    cp = common_pop_o;
    @(posedge clk_i);
    #1;
    if (up && uq.size() != 0) void'(uq.pop_front());
    if (cp && cq.size() != 0) void'(cq.pop_front());
    refresh();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    push_uop(ITYPE_STD, 32'h40);
    push_com(5'd0, 32'h0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if ({up, cp, valid_o, desync_o} !== 4'b0000)
        $display("FAIL reset_quiet%0d: pops/valid/desync got %b want 0000", i, {up, cp, valid_o, desync_o});
      else passed++;
      total++;
      if ({itype_o, iaddr_o, iretire_o, ilastsize_o, cause_o, tval_o} !== '0 || priv_o !== 2'd3)
        $display("FAIL reset_values%0d: iaddr %h cause %h tval %h priv %0d want 0/0/0/3",
                 i, iaddr_o, cause_o, tval_o, priv_o);
      else passed++;
    end
    rst_ni = 1'b1;
    cycle();
    total++;
    if (up !== 1'b1 || cp !== 1'b0 || valid_o !== 1'b1 || iaddr_o !== 32'h40)
      $display("FAIL reset_first_pop: up %b cp %b valid %b iaddr %h want 1 0 1 40", up, cp, valid_o, iaddr_o);
    else passed++;
    cq.delete();
    refresh();
    cycle();
    total++;
    if (valid_o !== 1'b0) $display("FAIL reset_drain: valid got %b want 0", valid_o);
    else passed++;
  endtask

  task automatic test_streaming();
    itype_e              ty [3];
    logic [INST_LEN-1:0] ad [3];
    ty[0] = ITYPE_STD; ty[1] = ITYPE_TB; ty[2] = ITYPE_NTB;
    ad[0] = 32'h100;   ad[1] = 32'h104;  ad[2] = 32'h108;
    for (int i = 0; i < 3; i++) push_uop(ty[i], ad[i]);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (up !== 1'b1 || cp !== 1'b0 || valid_o !== 1'b1 || iaddr_o !== ad[i] ||
          itype_o !== ty[i] || priv_o !== 2'd3)
        $display("FAIL stream%0d: up %b cp %b valid %b iaddr %h itype %0d priv %0d want 1 0 1 %h %0d 3",
                 i, up, cp, valid_o, iaddr_o, itype_o, priv_o, ad[i], ty[i]);
      else passed++;
    end
    cycle();
    total++;
    if (up !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL stream_drain: up %b valid %b want 0 0", up, valid_o);
    else passed++;
  endtask

  task automatic test_exception_wait();
    push_uop(ITYPE_EXC, 32'h200);
    push_uop(ITYPE_NTB, 32'h204);
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if (up !== 1'b0 || cp !== 1'b0 || valid_o !== 1'b0)
        $display("FAIL exc_wait%0d: up %b cp %b valid %b want 0 0 0", i, up, cp, valid_o);
      else passed++;
    end
    push_com(5'd2, 32'hDEAD, 2'd1);
    cycle();
    total++;
    if (up !== 1'b1 || cp !== 1'b1) $display("FAIL exc_pops: up %b cp %b want 1 1", up, cp);
    else passed++;
    total++;
    if (valid_o !== 1'b1 || itype_o !== ITYPE_EXC || iaddr_o !== 32'h200 ||
        cause_o !== 5'd2 || tval_o !== 32'hDEAD || priv_o !== 2'd1)
      $display("FAIL exc_record: valid %b itype %0d iaddr %h cause %0d tval %h priv %0d want 1 1 200 2 dead 1",
               valid_o, itype_o, iaddr_o, cause_o, tval_o, priv_o);
    else passed++;
    cycle();
    total++;
    if (up !== 1'b1 || cp !== 1'b0 || valid_o !== 1'b1 || itype_o !== ITYPE_NTB ||
        iaddr_o !== 32'h204 || priv_o !== 2'd1 || cause_o !== 5'd2)
      $display("FAIL exc_follow: up %b cp %b itype %0d iaddr %h priv %0d cause %0d want 1 0 4 204 1 2",
               up, cp, itype_o, iaddr_o, priv_o, cause_o);
    else passed++;
    cycle();
  endtask

  task automatic test_backpressure();
    push_uop(ITYPE_NTB, 32'h300);
    push_uop(ITYPE_TB, 32'h304);
    cycle();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      total++;
      if (up !== 1'b0 || cp !== 1'b0 || valid_o !== 1'b1 || iaddr_o !== 32'h300 ||
          itype_o !== ITYPE_NTB || priv_o !== 2'd1 || iretire_o !== 1'b1)
        $display("FAIL bp_hold%0d: up %b valid %b iaddr %h itype %0d priv %0d want 0 1 300 4 1",
                 i, up, valid_o, iaddr_o, itype_o, priv_o);
      else passed++;
    end
    ready_i = 1'b1;
    cycle();
    total++;
    if (up !== 1'b1 || valid_o !== 1'b1 || iaddr_o !== 32'h304 || itype_o !== ITYPE_TB)
      $display("FAIL bp_release: up %b valid %b iaddr %h itype %0d want 1 1 304 5", up, valid_o, iaddr_o, itype_o);
    else passed++;
    cycle();
  endtask

  task automatic test_desync();
    push_com(5'd3, 32'h55, 2'd2);
    for (int i = 0; i < 7; i++) cycle();
    total++;
    if (desync_o !== 1'b0) $display("FAIL desync_early: got %b want 0", desync_o);
    else passed++;
    cycle();
    total++;
    if (desync_o !== 1'b1) $display("FAIL desync_rise: got %b want 1", desync_o);
    else passed++;
    push_uop(ITYPE_EXC, 32'h400);
    cycle();
    total++;
    if (up !== 1'b1 || cp !== 1'b1 || valid_o !== 1'b1 || desync_o !== 1'b1 || cause_o !== 5'd3)
      $display("FAIL desync_sticky: up %b cp %b valid %b desync %b cause %0d want 1 1 1 1 3",
               up, cp, valid_o, desync_o, cause_o);
    else passed++;
    cycle();
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    total++;
    if (desync_o !== 1'b0) $display("FAIL desync_flush: got %b want 0", desync_o);
    else passed++;
    push_uop(ITYPE_NTB, 32'h500);
    cycle();
    total++;
    if (valid_o !== 1'b1 || cause_o !== 5'd0 || tval_o !== 32'h0 || priv_o !== 2'd2)
      $display("FAIL flush_held: valid %b cause %0d tval %h priv %0d want 1 0 0 2", valid_o, cause_o, tval_o, priv_o);
    else passed++;
    cycle();
  endtask

  task automatic test_flush();
    push_uop(ITYPE_NTB, 32'h600);
    push_uop(ITYPE_NTB, 32'h604);
    cycle();
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    total++;
    if (up !== 1'b0 || valid_o !== 1'b0 || priv_o !== 2'd2)
      $display("FAIL flush_full: up %b valid %b priv %0d want 0 0 2", up, valid_o, priv_o);
    else passed++;
    cycle();
    total++;
    if (up !== 1'b1 || valid_o !== 1'b1 || iaddr_o !== 32'h604)
      $display("FAIL flush_resume: up %b valid %b iaddr %h want 1 1 604", up, valid_o, iaddr_o);
    else passed++;
    cycle();
    push_uop(ITYPE_EXC, 32'h700);
    cycle();
    push_com(5'd1, 32'h77, 2'd0);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    total++;
    if (up !== 1'b0 || cp !== 1'b0 || valid_o !== 1'b0 || priv_o !== 2'd2)
      $display("FAIL flush_waitc: up %b cp %b valid %b priv %0d want 0 0 0 2", up, cp, valid_o, priv_o);
    else passed++;
    cycle();
    total++;
    if (up !== 1'b1 || cp !== 1'b1 || valid_o !== 1'b1 || iaddr_o !== 32'h700 ||
        cause_o !== 5'd1 || tval_o !== 32'h77 || priv_o !== 2'd0)
      $display("FAIL flush_waitc_resume: up %b cp %b iaddr %h cause %0d tval %h priv %0d want 1 1 700 1 77 0",
               up, cp, iaddr_o, cause_o, tval_o, priv_o);
    else passed++;
    cycle();
  endtask

  task automatic test_reset_mid();
    push_uop(ITYPE_NTB, 32'h800);
    push_uop(ITYPE_NTB, 32'h804);
    cycle();
    ready_i = 1'b0;
    rst_ni  = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || uop_pop_o !== 1'b0 || common_pop_o !== 1'b0 ||
        priv_o !== 2'd3 || iaddr_o !== 32'h0)
      $display("FAIL reset_mid: valid %b pop %b cpop %b priv %0d iaddr %h want 0 0 0 3 0",
               valid_o, uop_pop_o, common_pop_o, priv_o, iaddr_o);
    else passed++;
    ready_i = 1'b1;
    cycle();
    total++;
    if (up !== 1'b0) $display("FAIL reset_mid_pop: up %b want 0", up);
    else passed++;
    rst_ni = 1'b1;
    uq.delete();
    refresh();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_exception_wait();
    test_backpressure();
    test_desync();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mure_te_ingress_reader.md
Name: mure_te_ingress_reader

Overview:
Consumer end of the connector's uop and common FIFOs. Pops uop_entry_s entries and the sparse common_entry_s entries, re-joins them, and presents one fully populated instruction-block record per handshake to the trace encoder ingress. Sits between the connector's FIFOs and the encoder. Detects FIFO desynchronisation.

Parameters:
PRIV_RESET, 2'b11, privilege held after reset (M-mode).
DESYNC_TIMEOUT, 16, consecutive cycles of "common non-empty, uop empty" before desync_o is raised; 0 disables detection.
CNT_W, 8, width of the desync counter; must hold DESYNC_TIMEOUT.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush of the output stage and the desync state
uop_empty_i  in  1  uop FIFO empty
uop_entry_i  in  uop_entry_s  head of uop FIFO
uop_pop_o  out  1  pop uop FIFO this cycle
common_empty_i  in  1  common FIFO empty
common_entry_i  in  common_entry_s  head of common FIFO
common_pop_o  out  1  pop common FIFO this cycle
valid_o  out  1  record valid toward encoder
ready_i  in  1  encoder accepts record
itype_o  out  ITYPE_LEN  itype_e of the record
iaddr_o  out  INST_LEN  block address
iretire_o  out  1  retire flag
ilastsize_o  out  1  last instruction size
cause_o  out  CAUSE_LEN  trap cause
tval_o  out  XLEN  trap value
priv_o  out  PRIV_LEN  privilege
desync_o  out  1  sticky FIFO-desync flag

Behaviour:
- Reset: valid_o, uop_pop_o, common_pop_o, desync_o, itype_o, iaddr_o, iretire_o, ilastsize_o, cause_o, tval_o = 0; priv_o = PRIV_RESET; held common = {0, 0, PRIV_RESET}; FSM = EMPTY; desync counter = 0.
- Sparse pairing: exactly one common entry exists per uop whose itype is EXC, INT or ERET ("needs_common"). All other uops reuse the held common values.
- adv = !valid_o || ready_i. Output stage is a single register. Full throughput of one record per cycle.
- FSM states:
  - EMPTY: no record held.
  - FULL: record held. Outputs are stable while ready_i = 0.
  - WAIT_C: the uop at the head needs_common but the common FIFO is empty.
- Load rule, evaluated when adv && !uop_empty_i && !flush_i:
  - Uop does not need common: uop_pop_o = 1, combinational in the same cycle. Record is loaded with the held common. Next state FULL.
  - Uop needs common and !common_empty_i: uop_pop_o = common_pop_o = 1 in the same cycle. Record and held common both take common_entry_i. Next state FULL.
  - Uop needs common and common_empty_i: no pop. Next state WAIT_C. Any current record is retired if ready_i, so valid_o goes 0.
- WAIT_C exits to FULL in the cycle common_empty_i deasserts. Latency is one cycle from the common FIFO becoming non-empty to valid_o.
- adv with nothing to load: valid_o <= 0, state EMPTY.
- Pops are never asserted when adv = 0, or when the respective FIFO is empty.
- The common FIFO is never popped without a simultaneous uop pop.
- flush_i:
  - No pops in that cycle.
  - Next cycle: valid_o = 0, state EMPTY, desync counter = 0, desync_o = 0.
  - Held priv is preserved; held cause and tval are cleared.
  - flush_i overrides a simultaneous load.
- Desync counter:
  - Increments (saturating) each cycle common_empty_i = 0 && uop_empty_i = 1 && state != WAIT_C.
  - Clears on any cycle the condition is false.
  - desync_o sets when counter == DESYNC_TIMEOUT (non-zero) and stays set until flush_i or reset.
  - desync_o does not block normal operation.
- Reset asserted mid-transfer: all state returns immediately to reset values. No pop is issued while rst_ni = 0.

Decomposition:
- Add to mure_pkg: typedef enum for FSM states {EMPTY, FULL, WAIT_C}; typedef struct te_record_s {itype, iaddr, iretire, ilastsize, cause, tval, priv}; function needs_common(itype_e).
- Existing itype_e, uop_entry_s, common_entry_s are reused unchanged.
- One natural sub-module: mure_desync_monitor (counter plus sticky flag).

Test Plan:
- Reset: hold rst_ni = 0 for 3 cycles with both FIFOs non-empty -> all outputs 0, priv_o = 3, no pops; after release with ready_i = 1, first pop occurs on the first cycle.
- Streaming: three uops STD, TB, NTB (iaddr 0x100, 0x104, 0x108), ready_i = 1 -> uop_pop_o high for 3 consecutive cycles, valid_o high for 3 cycles with matching iaddr, common_pop_o never high, priv_o = 3.
- Exception wait: EXC uop at head, common FIFO empty for 4 cycles, then {cause = 2, tval = 0xDEAD, priv = 1} arrives -> stays in WAIT_C with no pop for 4 cycles; both pops in the arrival cycle; valid_o next cycle with cause_o = 2 and tval_o = 0xDEAD; a following NTB uop is emitted with priv_o = 1.
- Backpressure: valid_o = 1, ready_i = 0 for 5 cycles -> outputs bit-stable, no pops; ready_i = 1 -> next uop popped in that same cycle, new record on the following cycle.
- Desync: DESYNC_TIMEOUT = 8, common non-empty, uop empty -> desync_o rises after the 8th qualifying cycle and stays high after the uop FIFO fills; flush_i -> desync_o = 0 next cycle.
- Flush: flush_i while FULL, and separately while in WAIT_C -> valid_o = 0 next cycle, no pops during the flush cycle, priv_o retains its last value.
